seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a bank of common-anode 7-segment digits.
//  Holds a frame of 4-bit digit codes and selects one digit per scan slot.
//  Presents that digit's code to the downstream hex-to-segment decoder.
//  Codes: 0-9 digits, 10 dash, 15 blank. Sits between the datapath and the board display pins.
// PARAMETERS
//  NUM_DIGITS  8            number of digits scanned (2..8)
//  CLK_HZ      100_000_000  clk frequency
//  SCAN_HZ     1_000        per-digit slot rate; DIV = CLK_HZ/SCAN_HZ (>=2, integer)
// PORTS
//  clk         in   1              system clock, single clock domain
//  rst         in   1              reset, asynchronous, active-high
//  load_valid  in   1              new frame offered
//  load_ready  out  1              pending buffer empty; frame accepted when valid&ready
//  load_data   in   4*NUM_DIGITS   frame; digit i = load_data[4i+3:4i], digit 0 = rightmost
//  blank_en    in   1              1 = display dark
//  digit_code  out  4              code of the selected digit, to segment decoder
//  an          out  NUM_DIGITS     digit enables, active-low, one-hot-low when lit
//  frame_done  out  1              one-cycle pulse at each frame boundary
// BEHAVIOUR
//  Reset values:
//   - prescaler=0, idx=NUM_DIGITS-1, shadow=all 4'hF, pending empty
//   - an=all 1, digit_code=4'hF, frame_done=0, load_ready=1
//  Prescaler:
//   - counts 0..DIV-1; tick asserted in the cycle it equals DIV-1, then wraps to 0
//  Scan:
//   - on tick, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1
//   - an and digit_code are registered and update on the same edge from the new idx
//   - an[idx]=0 and all other bits 1; digit_code=shadow[idx]
//  Frame boundary:
//   - occurs on a tick where idx wraps NUM_DIGITS-1 -> 0
//   - frame_done=1 for exactly that one cycle after the edge
//   - if pending is full: shadow <= pending, pending emptied on the same edge
//   - digit 0 of the new frame already shows the new data, so there is no tearing
//   - the first tick after reset is a frame boundary
//  Handshake:
//   - load_ready = ~pending_full, derived from a register
//   - valid&ready captures load_data and sets pending_full
//   - while full, further valids stall, and load_data may change without effect
//   - accept and boundary in the same cycle: pending was empty, so the commit is a no-op
//     and the capture proceeds; the frame commits at the next boundary
//   - multiple loads between boundaries: only the first is accepted; the producer waits
//  blank_en:
//   - registered with the outputs: an=all 1 and digit_code=4'hF
//   - scanning, handshake and frame_done continue unaffected
//  Reset mid-frame: everything returns to reset values asynchronously; an pending frame is lost.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - at commit, compute a blank mask from the new frame
//   - digit i is blanked when its code is 0 and all higher digits are 0
//   - digit 0 is never blanked
//   - blanked digits output digit_code=4'hF, but their an bit still scans
//  Not defined: no mask; zeros are displayed as 0.
// STRUCTURE
//  Package seg_scan_pkg: CODE_DASH=4'hA, CODE_BLANK=4'hF, and a function computing DIV
//   with an elaboration check.
//  Sub-module seg_scan_tick: prescaler with parameter DIV, outputs tick.
//  Top: idx counter, pending/shadow registers, output registers, LZB mask logic.
// TESTING (NUM_DIGITS=4, CLK_HZ=4, SCAN_HZ=1 -> DIV=4)
//  1. Reset release, no load:
//     - frame_done pulses at first tick (cycle 4)
//     - an steps 1110,1101,1011,0111 every 4 cycles, digit_code=F throughout
//  2. Load 16'h1234 mid-frame:
//     - load_ready drops next cycle
//     - digit_code stays F until the wrap, then shows 4,3,2,1 with an[0..3]
//     - load_ready rises on the commit edge
//  3. Two loads 16'hAAAA then 16'h5555 before a boundary:
//     - the second stalls (ready=0); AAAA commits at the boundary
//     - 5555 is accepted the next cycle and commits at the following boundary
//  4. load_valid in the same cycle as the wrap tick while pending is empty:
//     - accepted; committed one frame later, never lost
//  5. blank_en=1 for 6 cycles: an=1111 and code=F; scan phase is unchanged when released.
//     Assert rst mid-frame: outputs go to reset values immediately.
//  6. LEADING_ZERO_BLANK_EN, load 16'h0070:
//     - codes 0,7,F,F on digits 0..3
//     - without the macro: 0,7,0,0

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
// Digit codes: 0-9 digits, CODE_DASH, CODE_BLANK.
package seg_scan_pkg;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Clock cycles per digit slot.
  function automatic int calc_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // The divider must be an exact integer and at least 2.
  function automatic bit div_ok(input int clk_hz, input int scan_hz);
    return (scan_hz > 0) && ((clk_hz % scan_hz) == 0) && ((clk_hz / scan_hz) >= 2);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-load channel between the datapath (master) and the scan controller (slave).
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  // valid/ready: a frame transfers on any clock edge where load_valid && load_ready.
  // Once load_valid is raised the master holds it and load_data until that edge;
  // ready never depends combinationally on valid.
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg_scan_tick.sv
// Slot prescaler: counts 0..DIV-1 and asserts tick while the count is DIV-1.
module seg_scan_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppress leading zeros at frame commit).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_HZ     = 100_000_000,
  parameter int SCAN_HZ    = 1_000
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_scan_ctrl_if.slave        load,
  input  logic                  blank_en,
  output logic [3:0]            digit_code,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);
  localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);
  localparam int IW  = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  if (!div_ok(CLK_HZ, SCAN_HZ)) begin : g_bad_div
    $error("seg_scan_ctrl: CLK_HZ/SCAN_HZ must be an integer >= 2");
  end
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_ctrl: NUM_DIGITS must be in 2..8");
  end

  logic                    tick;
  logic [IW-1:0]           idx, idx_nxt;
  logic                    wrap, commit, accept;
  logic                    pending_full;
  logic [4*NUM_DIGITS-1:0] pending, shadow, shadow_nxt;
  logic [NUM_DIGITS-1:0]   mask, mask_nxt;
  logic                    lit, lit_nxt;
  logic [3:0]              code_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0]   lzb;
  logic                    zero_run;
`endif

  seg_scan_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign load.load_ready = ~pending_full;
  assign accept          = load.load_valid & ~pending_full;

  always_comb begin
    wrap       = tick && (idx == LAST_IDX);
    commit     = wrap && pending_full;
    idx_nxt    = idx;
    if (tick) idx_nxt = (idx == LAST_IDX) ? '0 : idx + IW'(1);
    shadow_nxt = commit ? pending : shadow;
    // Digits stay dark from reset until the first slot tick selects digit 0.
    lit_nxt    = lit | tick;

`ifdef LEADING_ZERO_BLANK_EN
    lzb      = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (pending[4*i +: 4] == 4'h0);
      lzb[i]   = zero_run;
    end
    mask_nxt = commit ? lzb : mask;
`else
    mask_nxt = '0;
`endif

    // Outputs are computed from the post-edge idx/shadow so a new frame shows on digit 0 at once.
    if (blank_en || !lit_nxt) begin
      an_nxt   = '1;
      code_nxt = CODE_BLANK;
    end else begin
      an_nxt   = ~(NUM_DIGITS'(1) << idx_nxt);
      code_nxt = mask_nxt[idx_nxt] ? CODE_BLANK : shadow_nxt[4*idx_nxt +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= LAST_IDX;
      pending      <= '0;
      pending_full <= 1'b0;
      shadow       <= '1;
      mask         <= '0;
      lit          <= 1'b0;
      an           <= '1;
      digit_code   <= CODE_BLANK;
      frame_done   <= 1'b0;
    end else begin
      idx        <= idx_nxt;
      shadow     <= shadow_nxt;
      mask       <= mask_nxt;
      lit        <= lit_nxt;
      an         <= an_nxt;
      digit_code <= code_nxt;
      frame_done <= wrap;
      // Commit needs pending full and accept needs it empty, so they never collide.
      if (accept) begin
        pending      <= load.load_data;
        pending_full <= 1'b1;
      end else if (commit) begin
        pending_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, DIV=4).
module tb_seg_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blank_en = 1'b0;
  logic [3:0] digit_code;
  logic [3:0] an;
  logic       frame_done;
  int         n_cmp = 0;
  int         n_err = 0;

  seg_scan_ctrl_if #(.NUM_DIGITS(4)) lif ();

  seg_scan_ctrl #(.NUM_DIGITS(4), .CLK_HZ(4), .SCAN_HZ(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (lif),
    .blank_en   (blank_en),
    .digit_code (digit_code),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Release reset on a falling edge; prescaler starts at 0, first tick edge is the 4th rising edge.
  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lif.load_valid = 1'b0;
    lif.load_data = '0;
    repeat (2) @(posedge clk);
    release_reset();
    n_cmp++; if (an !== 4'b1111) begin n_err++; $display("FAIL reset_an: got %b want 1111", an); end
    n_cmp++; if (digit_code !== 4'hF) begin n_err++; $display("FAIL reset_code: got %h want f", digit_code); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd: got %b want 0", frame_done); end
    n_cmp++; if (lif.load_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", lif.load_ready); end
    step(3);
    n_cmp++; if (an !== 4'b1111 || frame_done !== 1'b0) begin n_err++; $display("FAIL pre_tick: got an=%b fd=%b want 1111/0", an, frame_done); end
    step(1); // E4
    n_cmp++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL first_fd: got %b want 1", frame_done); end
    n_cmp++; if (an !== 4'b1110 || digit_code !== 4'hF) begin n_err++; $display("FAIL slot0: got an=%b code=%h want 1110/f", an, digit_code); end
    step(1);
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL fd_pulse: got %b want 0", frame_done); end
    step(3); // E8
    n_cmp++; if (an !== 4'b1101 || digit_code !== 4'hF) begin n_err++; $display("FAIL slot1: got an=%b code=%h want 1101/f", an, digit_code); end
    step(4); // E12
    n_cmp++; if (an !== 4'b1011 || digit_code !== 4'hF) begin n_err++; $display("FAIL slot2: got an=%b code=%h want 1011/f", an, digit_code); end
    step(4); // E16
    n_cmp++; if (an !== 4'b0111 || digit_code !== 4'hF) begin n_err++; $display("FAIL slot3: got an=%b code=%h want 0111/f", an, digit_code); end
  endtask

  task automatic test_load();
    lif.load_valid = 1'b1;
    lif.load_data = 16'h1234;
    step(1); // E17 accept
    lif.load_valid = 1'b0;
    n_cmp++; if (lif.load_ready !== 1'b0) begin n_err++; $display("FAIL load_ready_drop: got %b want 0", lif.load_ready); end
    n_cmp++; if (digit_code !== 4'hF) begin n_err++; $display("FAIL load_no_tear: got %h want f", digit_code); end
    step(3); // E20 boundary
    n_cmp++; if (an !== 4'b1110 || digit_code !== 4'h4) begin n_err++; $display("FAIL load_d0: got an=%b code=%h want 1110/4", an, digit_code); end
    n_cmp++; if (lif.load_ready !== 1'b1 || frame_done !== 1'b1) begin n_err++; $display("FAIL load_commit: got ready=%b fd=%b want 1/1", lif.load_ready, frame_done); end
    step(4);
    n_cmp++; if (an !== 4'b1101 || digit_code !== 4'h3) begin n_err++; $display("FAIL load_d1: got an=%b code=%h want 1101/3", an, digit_code); end
    step(4);
    n_cmp++; if (an !== 4'b1011 || digit_code !== 4'h2) begin n_err++; $display("FAIL load_d2: got an=%b code=%h want 1011/2", an, digit_code); end
    step(4); // E32
    n_cmp++; if (an !== 4'b0111 || digit_code !== 4'h1) begin n_err++; $display("FAIL load_d3: got an=%b code=%h want 0111/1", an, digit_code); end
  endtask

  task automatic test_back_to_back();
    lif.load_valid = 1'b1;
    lif.load_data = 16'hAAAA;
    step(1); // E33 accept AAAA
    lif.load_data = 16'h5555;
    n_cmp++; if (lif.load_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready0: got %b want 0", lif.load_ready); end
    step(2); // E35 stalled
    n_cmp++; if (lif.load_ready !== 1'b0 || digit_code !== 4'h1) begin n_err++; $display("FAIL b2b_stall: got ready=%b code=%h want 0/1", lif.load_ready, digit_code); end
    step(1); // E36 commit AAAA
    n_cmp++; if (digit_code !== 4'hA || an !== 4'b1110 || lif.load_ready !== 1'b1) begin n_err++; $display("FAIL b2b_commit_a: got code=%h an=%b ready=%b want a/1110/1", digit_code, an, lif.load_ready); end
    step(1); // E37 accept 5555
    lif.load_valid = 1'b0;
    n_cmp++; if (lif.load_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept5: got %b want 0", lif.load_ready); end
    step(11); // E48
    n_cmp++; if (digit_code !== 4'hA || an !== 4'b0111) begin n_err++; $display("FAIL b2b_hold_a: got code=%h an=%b want a/0111", digit_code, an); end
    step(4); // E52 commit 5555
    n_cmp++; if (digit_code !== 4'h5 || an !== 4'b1110 || lif.load_ready !== 1'b1) begin n_err++; $display("FAIL b2b_commit_5: got code=%h an=%b ready=%b want 5/1110/1", digit_code, an, lif.load_ready); end
  endtask

  task automatic test_accept_at_wrap();
    step(15); // E67: wrap tick asserted this cycle
    n_cmp++; if (an !== 4'b0111 || lif.load_ready !== 1'b1) begin n_err++; $display("FAIL wrap_pre: got an=%b ready=%b want 0111/1", an, lif.load_ready); end
    lif.load_valid = 1'b1;
    lif.load_data = 16'h9876;
    step(1); // E68 boundary + accept
    lif.load_valid = 1'b0;
    n_cmp++; if (digit_code !== 4'h5 || frame_done !== 1'b1 || lif.load_ready !== 1'b0) begin n_err++; $display("FAIL wrap_accept: got code=%h fd=%b ready=%b want 5/1/0", digit_code, frame_done, lif.load_ready); end
    step(16); // E84
    n_cmp++; if (digit_code !== 4'h6 || an !== 4'b1110 || lif.load_ready !== 1'b1) begin n_err++; $display("FAIL wrap_commit: got code=%h an=%b ready=%b want 6/1110/1", digit_code, an, lif.load_ready); end
    step(4); // E88
    n_cmp++; if (digit_code !== 4'h7) begin n_err++; $display("FAIL wrap_d1: got %h want 7", digit_code); end
  endtask

  task automatic test_blank_and_reset();
    blank_en = 1'b1;
    step(1); // E89
    n_cmp++; if (an !== 4'b1111 || digit_code !== 4'hF) begin n_err++; $display("FAIL blank_on: got an=%b code=%h want 1111/f", an, digit_code); end
    step(5); // E94
    n_cmp++; if (an !== 4'b1111 || digit_code !== 4'hF) begin n_err++; $display("FAIL blank_hold: got an=%b code=%h want 1111/f", an, digit_code); end
    blank_en = 1'b0;
    step(1); // E95: idx advanced to 2 at E92
    n_cmp++; if (an !== 4'b1011 || digit_code !== 4'h8) begin n_err++; $display("FAIL blank_phase: got an=%b code=%h want 1011/8", an, digit_code); end
    step(5); // E100
    n_cmp++; if (frame_done !== 1'b1 || an !== 4'b1110 || digit_code !== 4'h6) begin n_err++; $display("FAIL blank_fd: got fd=%b an=%b code=%h want 1/1110/6", frame_done, an, digit_code); end
    step(5);
    lif.load_valid = 1'b1;
    lif.load_data = 16'h1111;
    step(1); // pending now full
    lif.load_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (an !== 4'b1111 || digit_code !== 4'hF) begin n_err++; $display("FAIL rst_mid_out: got an=%b code=%h want 1111/f", an, digit_code); end
    n_cmp++; if (lif.load_ready !== 1'b1 || frame_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_hs: got ready=%b fd=%b want 1/0", lif.load_ready, frame_done); end
    release_reset();
    step(4); // first boundary: pending frame was discarded
    n_cmp++; if (frame_done !== 1'b1 || an !== 4'b1110 || digit_code !== 4'hF) begin n_err++; $display("FAIL rst_lost: got fd=%b an=%b code=%h want 1/1110/f", frame_done, an, digit_code); end
  endtask

  task automatic test_leading_zero();
    logic [3:0] exp_hi;
`ifdef LEADING_ZERO_BLANK_EN
    exp_hi = 4'hF;
`else
    exp_hi = 4'h0;
`endif
    lif.load_valid = 1'b1;
    lif.load_data = 16'h0070;
    step(1);
    lif.load_valid = 1'b0;
    step(15); // E20 boundary
    n_cmp++; if (an !== 4'b1110 || digit_code !== 4'h0) begin n_err++; $display("FAIL lzb_d0: got an=%b code=%h want 1110/0", an, digit_code); end
    step(4);
    n_cmp++; if (an !== 4'b1101 || digit_code !== 4'h7) begin n_err++; $display("FAIL lzb_d1: got an=%b code=%h want 1101/7", an, digit_code); end
    step(4);
    n_cmp++; if (an !== 4'b1011 || digit_code !== exp_hi) begin n_err++; $display("FAIL lzb_d2: got an=%b code=%h want 1011/%h", an, digit_code, exp_hi); end
    step(4);
    n_cmp++; if (an !== 4'b0111 || digit_code !== exp_hi) begin n_err++; $display("FAIL lzb_d3: got an=%b code=%h want 0111/%h", an, digit_code, exp_hi); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_accept_at_wrap();
    test_blank_and_reset();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
